// File: rtl/odd_even_sorter_if.sv
// Handshake and status bundle for odd_even_sorter: input stream, output stream,
// queue-full flags and per-class accept counters.
interface odd_even_sorter_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_num;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_num;
   logic             out_is_odd;
   logic             even_full;
   logic             odd_full;
   logic [CNT_W-1:0] even_count;
   logic [CNT_W-1:0] odd_count;

   modport master (
      output in_valid, in_num, out_ready,
      input  in_ready, out_valid, out_num, out_is_odd,
             even_full, odd_full, even_count, odd_count
   );

   modport slave (
      input  in_valid, in_num, out_ready,
      output in_ready, out_valid, out_num, out_is_odd,
             even_full, odd_full, even_count, odd_count
   );
endinterface

// File: rtl/odd_even_sorter.sv
// Parity stream sorter: per-class FIFOs merged onto one output by round-robin.
// Define ODD_EVEN_SORTER_STRICT_PRIO_EN to give the even queue strict priority.

module odd_even (
   input  logic [3:0] num,
   output logic       is_odd
);
   assign is_odd = (num % 4'd2) != 4'd0;
endmodule

module oes_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [3:0] din,
   output logic [3:0] head,
   output logic       full,
   output logic       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

   logic [DEPTH-1:0][3:0] mem_q, mem_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]           cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
   end

   // Storage is not reset; the pointers and occupancy alone define validity.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == CNT_MAX);
   assign empty = (cnt_q == '0);
endmodule

module odd_even_sorter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   odd_even_sorter_if.slave     bus
);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic            is_odd, accept, load_en, gnt_vld, gnt_odd;
   logic [1:0]      push, pop, full, empty;
   logic [1:0][3:0] head;

   logic             out_valid_q, out_valid_d;
   logic [3:0]       out_num_q, out_num_d;
   logic             out_is_odd_q, out_is_odd_d;
   logic             last_odd_q, last_odd_d;
   logic [CNT_W-1:0] even_cnt_q, even_cnt_d, odd_cnt_q, odd_cnt_d;

   odd_even u_cls (.num(bus.in_num), .is_odd(is_odd));

   // Queue 0 holds even numbers, queue 1 odd numbers.
   for (genvar c = 0; c < 2; c++) begin : g_q
      oes_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[c]),
         .pop   (pop[c]),
         .din   (bus.in_num),
         .head  (head[c]),
         .full  (full[c]),
         .empty (empty[c])
      );
   end

   assign bus.in_ready = is_odd ? !full[1] : !full[0];
   assign accept       = bus.in_valid && bus.in_ready;
   assign push[1]      = accept && is_odd;
   assign push[0]      = accept && !is_odd;

   always_comb begin
      load_en = !out_valid_q || bus.out_ready;
      gnt_vld = !empty[0] || !empty[1];
      if (!empty[0] && !empty[1]) begin
`ifdef ODD_EVEN_SORTER_STRICT_PRIO_EN
         gnt_odd = 1'b0;
`else
         gnt_odd = !last_odd_q;
`endif
      end else begin
         gnt_odd = !empty[1];
      end
      pop[1] = load_en && gnt_vld && gnt_odd;
      pop[0] = load_en && gnt_vld && !gnt_odd;

      out_valid_d  = out_valid_q;
      out_num_d    = out_num_q;
      out_is_odd_d = out_is_odd_q;
      last_odd_d   = last_odd_q;
      if (load_en) begin
         out_valid_d = gnt_vld;
         if (gnt_vld) begin
            out_num_d    = gnt_odd ? head[1] : head[0];
            out_is_odd_d = gnt_odd;
            last_odd_d   = gnt_odd;
         end
      end

      even_cnt_d = even_cnt_q;
      odd_cnt_d  = odd_cnt_q;
      if (push[0] && even_cnt_q != '1) even_cnt_d = even_cnt_q + C_ONE;
      if (push[1] && odd_cnt_q != '1)  odd_cnt_d  = odd_cnt_q + C_ONE;
   end

   // last_odd resets to 1 so that even wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_num_q    <= '0;
         out_is_odd_q <= 1'b0;
         last_odd_q   <= 1'b1;
         even_cnt_q   <= '0;
         odd_cnt_q    <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_num_q    <= out_num_d;
         out_is_odd_q <= out_is_odd_d;
         last_odd_q   <= last_odd_d;
         even_cnt_q   <= even_cnt_d;
         odd_cnt_q    <= odd_cnt_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_num    = out_num_q;
   assign bus.out_is_odd = out_is_odd_q;
   assign bus.even_full  = full[0];
   assign bus.odd_full   = full[1];
   assign bus.even_count = even_cnt_q;
   assign bus.odd_count  = odd_cnt_q;
endmodule

// File: tb/tb_odd_even_sorter.sv
// Bench for odd_even_sorter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_odd_even_sorter;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   odd_even_sorter_if #(.CNT_W(CNT_W)) bus ();
   odd_even_sorter_if #(.CNT_W(2))     sbus ();

   odd_even_sorter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   odd_even_sorter #(.DEPTH(DEPTH), .CNT_W(2))     dut_sat (.clk(clk), .rst(rst), .bus(sbus));

   int n_chk = 0;
   int n_pass = 0;

   // reference model state
   int eq[$];
   int oq[$];
   int got[$];
   int exp_q[$];
   bit m_ov, m_odd, m_last_odd;
   int m_num, m_ec, m_oc;
   bit acc;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === 32'(exp)) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_seq(input string tag);
      chk({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
   endtask

   // One clock: drive, compare all outputs to the model, advance the model.
   task automatic step(input bit r, input bit v, input int num, input bit ordy);
      bit m_rdy, m_is_odd, go, gv;
      rst = r;
      bus.in_valid  = v;
      bus.in_num    = num[3:0];
      bus.out_ready = ordy;
      #1;
      m_is_odd = (num % 2) == 1;
      m_rdy    = m_is_odd ? (oq.size() < DEPTH) : (eq.size() < DEPTH);
      chk("in_ready",   bus.in_ready,   m_rdy);
      chk("out_valid",  bus.out_valid,  m_ov);
      chk("out_num",    bus.out_num,    m_num);
      chk("out_is_odd", bus.out_is_odd, m_odd);
      chk("even_full",  bus.even_full,  eq.size() == DEPTH);
      chk("odd_full",   bus.odd_full,   oq.size() == DEPTH);
      chk("even_count", bus.even_count, m_ec);
      chk("odd_count",  bus.odd_count,  m_oc);
      if (bus.out_valid === 1'b1 && ordy) got.push_back(int'(bus.out_num));
      acc = v && m_rdy && !r;
      if (r) begin
         eq.delete(); oq.delete();
         m_ov = 0; m_num = 0; m_odd = 0; m_last_odd = 1; m_ec = 0; m_oc = 0;
      end else begin
         if (!m_ov || ordy) begin
            gv = (eq.size() > 0) || (oq.size() > 0);
            if (eq.size() > 0 && oq.size() > 0) begin
`ifdef ODD_EVEN_SORTER_STRICT_PRIO_EN
               go = 0;
`else
               go = !m_last_odd;
`endif
            end else go = oq.size() > 0;
            if (gv) begin
               m_num = go ? oq.pop_front() : eq.pop_front();
               m_odd = go; m_last_odd = go; m_ov = 1;
            end else m_ov = 0;
         end
         if (acc) begin
            if (m_is_odd) begin oq.push_back(num); if (m_oc < CMAX) m_oc++; end
            else begin eq.push_back(num); if (m_ec < CMAX) m_ec++; end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit pend;
      rst = 1'b1;
      bus.in_valid = 0; bus.in_num = 0; bus.out_ready = 0;
      sbus.in_valid = 0; sbus.in_num = 0; sbus.out_ready = 0;
      m_last_odd = 1;
      @(posedge clk); #1;

      // reset with in_valid held high, then first accept after release
      step(1, 1, 4, 0);
      step(1, 1, 4, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 1, 3, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // in-order stream 0..9
      step(1, 0, 0, 1);
      got.delete();
      for (int i = 0; i < 10; i++) step(0, 1, i, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      chk_seq("inorder");
      chk("inorder_even_cnt", bus.even_count, 5);
      chk("inorder_odd_cnt",  bus.odd_count, 5);

      // backpressure and full even queue
      step(1, 0, 0, 0);
      got.delete();
      for (int i = 0; i < 5; i++) step(0, 1, 2 * i, 0);
      chk("bp_even_full", bus.even_full, 1);
      chk("bp_out_held",  bus.out_num, 0);
      step(0, 1, 10, 0);
      step(0, 1, 1, 0);
      pend = 1;
      for (int i = 0; i < 10; i++) begin
         step(0, pend, 10, 1);
         if (acc) pend = 0;
      end
      exp_q = '{0, 1, 2, 4, 6, 8, 10};
      chk_seq("backpressure");

      // arbitration fairness
      step(1, 0, 0, 0);
      got.delete();
      for (int i = 0; i < 6; i++) step(0, 1, i, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
`ifdef ODD_EVEN_SORTER_STRICT_PRIO_EN
      exp_q = '{0, 2, 4, 1, 3, 5};
`else
      exp_q = '{0, 1, 2, 3, 4, 5};
`endif
      chk_seq("arb");

      // reset mid-operation discards everything queued
      step(1, 0, 0, 0);
      got.delete();
      step(0, 1, 0, 0); step(0, 1, 2, 0); step(0, 1, 1, 0);
      step(0, 1, 3, 0); step(0, 1, 4, 0);
      chk("mid_pre_valid", bus.out_valid, 1);
      step(1, 0, 0, 0);
      chk("mid_valid",   bus.out_valid, 0);
      chk("mid_efull",   bus.even_full, 0);
      chk("mid_ecount",  bus.even_count, 0);
      chk("mid_ocount",  bus.odd_count, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      chk("mid_no_output", got.size(), 0);

      // random traffic
      step(1, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0);

      // counter saturation on the 2-bit instance
      step(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         sbus.in_valid = 1; sbus.in_num = 4'(2 * i + 1); sbus.out_ready = 1;
         @(posedge clk); #1;
         chk("sat_odd_count",  sbus.odd_count, (i < 3) ? i + 1 : 3);
         chk("sat_even_count", sbus.even_count, 0);
      end
      sbus.in_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/odd_even_sorter.md
Name: odd_even_sorter

Overview:
- Stream controller that classifies incoming 4-bit numbers by parity.
- Instantiates the existing odd_even classifier as its datapath.
- Steers each accepted number into a per-class FIFO (even queue, odd queue).
- Shares a single output port between the two queues via round-robin arbitration; keeps saturating per-class accept counters for status/debug.

Parameters:
DEPTH, 4, entries per class FIFO (power of 2, >=2)
CNT_W, 8, width of odd_count / even_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input number valid
in_ready  output  1  input accepted when in_valid && in_ready
in_num  input  4  number to classify
out_valid  output  1  output register holds a number
out_ready  input  1  consumer accepts when out_valid && out_ready
out_num  output  4  number presented
out_is_odd  output  1  1 = out_num came from odd queue
even_full  output  1  even FIFO holds DEPTH entries
odd_full  output  1  odd FIFO holds DEPTH entries
even_count  output  CNT_W  count of accepted even numbers
odd_count  output  CNT_W  count of accepted odd numbers

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_num=0, out_is_odd=0, both FIFOs empty, even_full=0, odd_full=0, counters=0, last_grant=ODD (even wins first tie).
- Classification: even/odd from the odd_even instance on in_num (equivalent to in_num[0]).
- in_ready is combinational: !odd_full when in_num odd, !even_full when even; it is independent of in_valid. There is no same-cycle bypass: a full queue popped this cycle still drives in_ready=0 this cycle.
- Accept (in_valid && in_ready): push in_num into the target FIFO at the clock edge; increment that class counter, saturating at all-ones.
- Output register load enable: load_en = !out_valid || out_ready.
- When load_en is set, the arbiter picks a grant:
  - both queues non-empty -> grant the class opposite last_grant;
  - only one non-empty -> grant it;
  - both empty -> no grant, out_valid<=0 (out_num/out_is_odd hold their last value).
- On grant: pop the head of the granted FIFO into out_num, set out_is_odd to the granted class, set out_valid<=1, last_grant<=granted class.
- Latency: a number accepted at edge N with an empty output register appears with out_valid=1 after edge N+1. With out_ready held high, sustained throughput is 1 number/cycle.
- out_num/out_is_odd are stable while out_valid && !out_ready.
- Simultaneous push and pop on the same FIFO: both take effect; occupancy is unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy count of width log2(DEPTH)+1 drives full/empty.
- Reset mid-operation: all queued and registered data is discarded, counters clear, and outputs return to reset values on the edge where rst=1. in_ready stays valid combinationally during reset (both queues empty -> 1).

Optional Feature:
- Macro: ODD_EVEN_SORTER_STRICT_PRIO_EN.
- Defined: the even queue has strict priority; when both queues are non-empty, even is always granted. last_grant is still updated but ignored.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, counters=0, in_ready=1; after release, first output appears only after a new accept.
- In-order stream: out_ready=1, send 0..9 back-to-back -> out_num sequence 0,1,2,...,9 (alternating class, one per cycle after 1-cycle latency); even_count=5, odd_count=5.
- Backpressure and full: out_ready=0, send 0,2,4,6,8 (DEPTH=4):
  - out register holds 0; 2,4,6,8 are queued; even_full=1.
  - in_num=10 sees in_ready=0 and stalls; in_num=1 is accepted.
  - Releasing out_ready yields 0,1,2,4,6,8,10 (round-robin, odd served once available).
- Round-robin fairness: preload 3 evens (0,2,4) and 3 odds (1,3,5) with out_ready=0, then release -> 0 (already registered), 1,2,3,4,5. With ODD_EVEN_SORTER_STRICT_PRIO_EN -> 0,2,4,1,3,5.
- Counter saturation: CNT_W=2, accept 6 odd numbers -> odd_count goes 1,2,3,3,3,3; even_count=0.
- Mid-operation reset: with both queues partially filled and out_valid=1, assert rst for 1 cycle -> next cycle out_valid=0, full flags 0, counters 0; queued numbers never appear at the output.
